// File: rtl/xbee_pkg.sv
// Shared definitions for the XBee command decoder: framing constants, opcodes,
// FSM state encoding and frame-integrity helpers.
package xbee_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

    localparam logic [7:0] OP_GOTO = 8'h01;
    localparam logic [7:0] OP_STOP = 8'h02;
    localparam logic [7:0] OP_PICK = 8'h03;
    localparam logic [7:0] OP_DROP = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GET_CMD = 2'd1,
        ST_GET_ARG = 2'd2,
        ST_GET_CHK = 2'd3
    } state_e;

    function automatic logic [7:0] frame_checksum(input logic [7:0] cmd, input logic [7:0] arg);
        return cmd + arg;
    endfunction

    function automatic logic opcode_legal(input logic [7:0] cmd);
        logic legal;
        case (cmd)
            OP_GOTO, OP_STOP, OP_PICK, OP_DROP: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts idle cycles while enabled; pulses expired on the last cycle of the
// window unless a clear arrives in that same cycle.
module inactivity_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;
    logic          at_last_s;

    assign at_last_s = (count_r == LAST);
    assign expired   = enable && !clear && at_last_s;

    // Idle-cycle counter, restarted by every byte and whenever the window closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear || !enable || at_last_s) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

endmodule

// File: rtl/xbee_cmd_decoder.sv
// Frames the XBee UART byte stream into 4-byte SOF/CMD/ARG/CHK packets and
// holds each validated command in a valid/ready output register.
module xbee_cmd_decoder
    import xbee_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0]  SOF            = SOF_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_err,
    output logic       overrun,
    output logic [7:0] err_count
);

    state_e     state_r;
    state_e     state_nxt_s;
    logic [7:0] cmd_byte_r;
    logic [7:0] arg_byte_r;
    logic       cmd_ld_s;
    logic       arg_ld_s;
    logic       good_s;
    logic       bad_s;
    logic       timeout_s;
    logic       expired_s;
    logic       load_s;

    logic       cmd_valid_r;
    logic [2:0] cmd_code_r;
    logic [7:0] cmd_arg_r;
    logic       frame_err_r;
    logic       overrun_r;
    logic [7:0] err_count_r;

    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_valid),
        .enable (state_r != ST_IDLE),
        .expired(expired_s)
    );

    // Frame FSM next state and per-byte decisions; a byte always beats the timeout
    always_comb begin
        state_nxt_s = state_r;
        cmd_ld_s    = 1'b0;
        arg_ld_s    = 1'b0;
        good_s      = 1'b0;
        bad_s       = 1'b0;
        timeout_s   = 1'b0;
        if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_data == SOF) begin
                        state_nxt_s = ST_GET_CMD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_GET_CMD: begin
                    cmd_ld_s    = 1'b1;
                    state_nxt_s = ST_GET_ARG;
                end
                ST_GET_ARG: begin
                    arg_ld_s    = 1'b1;
                    state_nxt_s = ST_GET_CHK;
                end
                ST_GET_CHK: begin
                    state_nxt_s = ST_IDLE;
                    if ((frame_checksum(cmd_byte_r, arg_byte_r) == rx_data) && opcode_legal(cmd_byte_r)) begin
                        good_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else if (expired_s) begin
            timeout_s   = 1'b1;
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign load_s = good_s && (!cmd_valid_r || cmd_ready);

    // FSM state and operand latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cmd_byte_r <= 8'h00;
            arg_byte_r <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            if (cmd_ld_s) begin
                cmd_byte_r <= rx_data;
            end
            if (arg_ld_s) begin
                arg_byte_r <= rx_data;
            end
        end
    end

    // Command holding register: reload on consume, otherwise hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= 3'd0;
            cmd_arg_r   <= 8'h00;
            overrun_r   <= 1'b0;
        end else begin
            overrun_r <= good_s && cmd_valid_r && !cmd_ready;
            if (load_s) begin
                cmd_valid_r <= 1'b1;
                cmd_code_r  <= cmd_byte_r[2:0];
                cmd_arg_r   <= arg_byte_r;
            end else if (cmd_ready) begin
                cmd_valid_r <= 1'b0;
            end
        end
    end

    // Rejected-frame pulse and saturating error counter (overruns excluded)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
            err_count_r <= 8'h00;
        end else begin
            frame_err_r <= bad_s || timeout_s;
            if ((bad_s || timeout_s) && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'h01;
            end
        end
    end

    assign cmd_valid = cmd_valid_r;
    assign cmd_code  = cmd_code_r;
    assign cmd_arg   = cmd_arg_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_xbee_cmd_decoder.sv
// Directed self-checking bench for xbee_cmd_decoder with a short timeout window.
module tb_xbee_cmd_decoder;

    localparam int unsigned TMO = 20;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_err;
    logic       overrun;
    logic [7:0] err_count;

    int checks;
    int errors;

    xbee_cmd_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .SOF           (8'h7E)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_code (cmd_code),
        .cmd_arg  (cmd_arg),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is captured on the next posedge.
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        put(8'h7E);
        put(c);
        put(a);
        put(k);
        rx_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        idle(2);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code",  32'(cmd_code),  32'd0);
        check("rst_cmd_arg",   32'(cmd_arg),   32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Junk in IDLE is ignored, then a GOTO node 5
        cmd_ready = 1'b1;
        put(8'h55);
        frame(8'h01, 8'h05, 8'h06);
        check("goto_valid", 32'(cmd_valid), 32'd1);
        check("goto_code",  32'(cmd_code),  32'd1);
        check("goto_arg",   32'(cmd_arg),   32'h05);
        check("goto_noerr", 32'(frame_err), 32'd0);
        check("goto_cnt",   32'(err_count), 32'd0);
        idle(1);
        check("goto_consumed", 32'(cmd_valid), 32'd0);

        // Bad checksum
        frame(8'h02, 8'h00, 8'h00);
        check("badchk_err",   32'(frame_err), 32'd1);
        check("badchk_cnt",   32'(err_count), 32'd1);
        check("badchk_valid", 32'(cmd_valid), 32'd0);
        idle(1);
        check("badchk_pulse_end", 32'(frame_err), 32'd0);

        // Illegal opcode with a correct checksum
        frame(8'h09, 8'h00, 8'h09);
        check("badop_err",   32'(frame_err), 32'd1);
        check("badop_cnt",   32'(err_count), 32'd2);
        check("badop_valid", 32'(cmd_valid), 32'd0);
        idle(1);

        // Stall after CMD: timeout fires TMO cycles after the last byte
        put(8'h7E);
        put(8'h01);
        idle(TMO - 1);
        check("tmo_early", 32'(frame_err), 32'd0);
        idle(1);
        check("tmo_err", 32'(frame_err), 32'd1);
        check("tmo_cnt", 32'(err_count), 32'd3);
        idle(1);
        frame(8'h02, 8'h00, 8'h02);
        check("stop_valid", 32'(cmd_valid), 32'd1);
        check("stop_code",  32'(cmd_code),  32'd2);
        check("stop_arg",   32'(cmd_arg),   32'h00);
        check("stop_noerr", 32'(frame_err), 32'd0);
        idle(1);

        // Overrun: back-to-back frames with the consumer stalled
        cmd_ready = 1'b0;
        frame(8'h03, 8'h01, 8'h04);
        check("pick_valid", 32'(cmd_valid), 32'd1);
        check("pick_code",  32'(cmd_code),  32'd3);
        frame(8'h04, 8'h02, 8'h06);
        check("ovr_pulse", 32'(overrun),   32'd1);
        check("ovr_valid", 32'(cmd_valid), 32'd1);
        check("ovr_code",  32'(cmd_code),  32'd3);
        check("ovr_arg",   32'(cmd_arg),   32'h01);
        check("ovr_cnt",   32'(err_count), 32'd3);
        check("ovr_noerr", 32'(frame_err), 32'd0);
        idle(1);
        check("ovr_once", 32'(overrun),   32'd0);
        check("ovr_hold", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        idle(1);
        check("ready_clears", 32'(cmd_valid), 32'd0);

        // Reset mid-frame discards it; trailing bytes land in IDLE
        put(8'h7E);
        put(8'h01);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        put(8'h05);
        put(8'h06);
        idle(2);
        check("rstmid_valid", 32'(cmd_valid), 32'd0);
        check("rstmid_err",   32'(frame_err), 32'd0);
        check("rstmid_cnt",   32'(err_count), 32'd0);

        // Saturation of the error counter
        for (int i = 0; i < 255; i++) frame(8'h02, 8'h00, 8'h00);
        check("sat_255", 32'(err_count), 32'd255);
        for (int i = 0; i < 45; i++) frame(8'h02, 8'h00, 8'h00);
        check("sat_hold",  32'(err_count), 32'd255);
        check("sat_pulse", 32'(frame_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
